// File: rtl/da_fir_serial_if.sv
// Handshake bundle for the serial DA FIR: sample-in valid/ready, result-out
// valid/ready, plus the LUT and busy debug taps.
interface da_fir_serial_if #(
    parameter int W  = 8,
    parameter int OW = 18,
    parameter int LW = 10
) ();
    logic                 in_valid;
    logic                 in_ready;
    logic [W-1:0]         x_in;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [OW-1:0] y;
    logic signed [LW-1:0] lut;
    logic                 busy;

    modport slave (
        input  in_valid, x_in, out_ready,
        output in_ready, out_valid, y, lut, busy
    );

    modport master (
        output in_valid, x_in, out_ready,
        input  in_ready, out_valid, y, lut, busy
    );
endinterface

// File: rtl/da_fir_serial.sv
// Bit-serial distributed-arithmetic FIR: N-tap delay line, MSB-first
// accumulation over W cycles per sample, LUT built from COEFS at elaboration.
module da_fir_serial #(
    parameter int              N      = 4,
    parameter int              W      = 8,
    parameter int              CW     = 8,
    parameter logic [N*CW-1:0] COEFS  = {8'sd3, 8'sd12, 8'sd12, 8'sd3},
    parameter int              SIGNED = 1
) (
    input logic             clk,
    input logic             reset_n,
    da_fir_serial_if.slave  bus
);
    localparam int LW   = CW + $clog2(N);
    localparam int OW   = W + CW + $clog2(N);
    localparam int CNTW = (W > 1) ? $clog2(W) : 1;
    localparam int NE   = 1 << N;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Entry a holds the sum of every coefficient whose tap bit is set in a.
    function automatic logic [NE*LW-1:0] buildLut();
        logic [NE*LW-1:0]     tbl;
        logic signed [LW-1:0] sum;
        tbl = '0;
        for (int a = 0; a < NE; a++) begin
            sum = '0;
            for (int k = 0; k < N; k++) begin
                if (a[k]) sum = sum + LW'($signed(COEFS[k*CW +: CW]));
            end
            tbl[a*LW +: LW] = sum;
        end
        return tbl;
    endfunction

    localparam logic [NE*LW-1:0] LUT_TABLE = buildLut();

    state_t               r_state;
    state_t               w_nextState;
    logic [W-1:0]         r_d  [N];
    logic [W-1:0]         r_sr [N];
    logic signed [OW-1:0] r_acc;
    logic signed [OW-1:0] r_y;
    logic [CNTW-1:0]      r_cnt;

    logic [N-1:0]         w_addr;
    logic signed [LW-1:0] w_lut;
    logic signed [OW-1:0] w_lutExt;
    logic signed [OW-1:0] w_term;
    logic signed [OW-1:0] w_accNext;
    logic                 w_inReady;
    logic                 w_outValid;
    logic                 w_busy;
    logic                 w_accept;
    logic                 w_lastBit;

    always_comb begin
        w_addr = '0;
        for (int k = 0; k < N; k++) w_addr[k] = r_sr[k][W-1];
    end

    assign w_lut     = LUT_TABLE[int'(w_addr)*LW +: LW];
    assign w_lutExt  = OW'(w_lut);
    // The first (MSB) bit of a two's-complement sample carries negative weight.
    assign w_term    = (SIGNED != 0 && r_cnt == CNTW'(W-1)) ? -w_lutExt : w_lutExt;
    assign w_accNext = (r_acc <<< 1) + w_term;
    assign w_lastBit = (r_cnt == '0);
    assign w_accept  = bus.in_valid && w_inReady;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: if (w_accept) w_nextState = RUN;
            RUN:  if (w_lastBit) w_nextState = DONE;
            DONE: if (bus.out_ready) w_nextState = w_accept ? RUN : IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        w_inReady  = 1'b0;
        w_outValid = 1'b0;
        w_busy     = 1'b0;
        case (r_state)
            IDLE: w_inReady = reset_n;
            RUN:  w_busy = 1'b1;
            DONE: begin
                w_outValid = 1'b1;
                w_inReady  = bus.out_ready;
            end
            default: ;
        endcase
    end

    // Accepting a sample always reloads the taps, even straight out of DONE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < N; k++) begin
                r_d[k]  <= '0;
                r_sr[k] <= '0;
            end
            r_acc <= '0;
            r_cnt <= '0;
            r_y   <= '0;
        end else if (w_accept) begin
            r_d[0]  <= bus.x_in;
            r_sr[0] <= bus.x_in;
            for (int k = 1; k < N; k++) begin
                r_d[k]  <= r_d[k-1];
                r_sr[k] <= r_d[k-1];
            end
            r_acc <= '0;
            r_cnt <= CNTW'(W-1);
        end else if (r_state == RUN) begin
            for (int k = 0; k < N; k++) r_sr[k] <= r_sr[k] << 1;
            r_acc <= w_accNext;
            r_cnt <= r_cnt - 1'b1;
            if (w_lastBit) r_y <= w_accNext;
        end
    end

    assign bus.in_ready  = w_inReady;
    assign bus.out_valid = w_outValid;
    assign bus.busy      = w_busy;
    assign bus.y         = r_y;
    assign bus.lut       = w_lut;
endmodule

// File: tb/tb_da_fir_serial.sv
// Directed bench for da_fir_serial: default signed filter, an unsigned variant
// and a 3-tap/6-bit variant checked against a convolution model.
module tb_da_fir_serial;
    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    da_fir_serial_if #(.W(8), .OW(18), .LW(10)) bus0 ();
    da_fir_serial_if #(.W(8), .OW(18), .LW(10)) bus1 ();
    da_fir_serial_if #(.W(6), .OW(16), .LW(10)) bus2 ();

    da_fir_serial dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0.slave));

    da_fir_serial #(.SIGNED(0)) dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1.slave));

    da_fir_serial #(
        .N(3), .W(6), .CW(8),
        .COEFS({-8'sd5, 8'sd7, 8'sd2}),
        .SIGNED(1)
    ) dut2 (.clk(clk), .reset_n(reset_n), .bus(bus2.slave));

    typedef struct {
        int x;
        int yExp;
    } vec_t;

    vec_t vecs[18];

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Offers one sample to dut0, then checks result latency and value.
    task automatic applyStimulus(input int x, input int expY, input string name);
        int cyc;
        @(negedge clk);
        bus0.in_valid = 1'b1;
        bus0.x_in     = x[7:0];
        cyc = 0;
        while (!bus0.in_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if (!bus0.in_ready) begin
            checkOutput({name, "_accept"}, 0, 1);
            bus0.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bus0.in_valid = 1'b0;
        cyc = 0;
        while (!bus0.out_valid && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checkOutput({name, "_latency"}, cyc, 8);
        checkOutput({name, "_y"}, int'(bus0.y), expY);
    endtask

    initial begin
        int     cyc;
        int     bad;
        int     expY;
        int     expL;
        int     lutErr;
        int     hist[3];
        logic [5:0] hb[3];
        logic [5:0] xs;
        int     c2[3];
        int     uExp[4];

        vecs[0]  = '{1, 3};       vecs[1]  = '{0, 12};
        vecs[2]  = '{0, 12};      vecs[3]  = '{0, 3};
        vecs[4]  = '{0, 0};
        vecs[5]  = '{-128, -384}; vecs[6]  = '{0, -1536};
        vecs[7]  = '{0, -1536};   vecs[8]  = '{0, -384};
        vecs[9]  = '{0, 0};
        vecs[10] = '{-128, -384}; vecs[11] = '{-128, -1920};
        vecs[12] = '{-128, -3456};vecs[13] = '{-128, -3840};
        vecs[14] = '{127, -3075}; vecs[15] = '{127, -15};
        vecs[16] = '{127, 3045};  vecs[17] = '{127, 3810};
        c2   = '{2, 7, -5};
        uExp = '{765, 3825, 6885, 7650};

        reset_n = 1'b0;
        bus0.in_valid = 1'b0; bus0.x_in = '0; bus0.out_ready = 1'b1;
        bus1.in_valid = 1'b0; bus1.x_in = '0; bus1.out_ready = 1'b1;
        bus2.in_valid = 1'b0; bus2.x_in = '0; bus2.out_ready = 1'b1;
        #22;
        checkOutput("rst_out_valid", int'(bus0.out_valid), 0);
        checkOutput("rst_y", int'(bus0.y), 0);
        checkOutput("rst_busy", int'(bus0.busy), 0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        checkOutput("rst_in_ready", int'(bus0.in_ready), 1);

        for (int i = 0; i < 18; i++) begin
            applyStimulus(vecs[i].x, vecs[i].yExp, $sformatf("vec%0d", i));
        end

        // Backpressure: let the last result drain, then hold out_ready low.
        @(posedge clk);
        #1;
        bus0.out_ready = 1'b0;
        applyStimulus(5, 3444, "bp_first");
        @(negedge clk);
        bus0.in_valid = 1'b1;
        bus0.x_in     = 8'd0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (bus0.y != 18'sd3444 || !bus0.out_valid || bus0.in_ready || bus0.busy) bad++;
        end
        checkOutput("bp_hold_bad_cycles", bad, 0);
        @(negedge clk);
        bus0.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus0.in_valid = 1'b0;
        checkOutput("bp_accept_busy", int'(bus0.busy), 1);
        checkOutput("bp_valid_drop", int'(bus0.out_valid), 0);
        cyc = 0;
        while (!bus0.out_valid && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checkOutput("bp_next_latency", cyc, 8);
        checkOutput("bp_next_y", int'(bus0.y), 1965);

        // Reset in the fourth RUN cycle must wipe the result and history.
        @(negedge clk);
        bus0.in_valid = 1'b1;
        bus0.x_in     = 8'd77;
        @(posedge clk);
        #1;
        bus0.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("midrun_busy", int'(bus0.busy), 1);
        reset_n = 1'b0;
        #1;
        checkOutput("midrun_out_valid", int'(bus0.out_valid), 0);
        checkOutput("midrun_y", int'(bus0.y), 0);
        checkOutput("midrun_busy_cleared", int'(bus0.busy), 0);
        @(negedge clk);
        reset_n = 1'b1;
        applyStimulus(1, 3, "after_rst_imp0");
        applyStimulus(0, 12, "after_rst_imp1");
        applyStimulus(0, 12, "after_rst_imp2");

        // Unsigned variant with full-scale 255 samples.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus1.in_valid = 1'b1;
            bus1.x_in     = 8'd255;
            cyc = 0;
            while (!bus1.in_ready && cyc < 50) begin
                @(negedge clk);
                cyc++;
            end
            @(posedge clk);
            #1;
            bus1.in_valid = 1'b0;
            cyc = 0;
            while (!bus1.out_valid && cyc < 20) begin
                @(posedge clk);
                #1;
                cyc++;
            end
            checkOutput($sformatf("uns%0d_latency", i), cyc, 8);
            checkOutput($sformatf("uns%0d_y", i), int'(bus1.y), uExp[i]);
        end

        // 3-tap, 6-bit variant against a convolution and LUT model.
        hist = '{0, 0, 0};
        hb   = '{6'd0, 6'd0, 6'd0};
        for (int i = 0; i < 500; i++) begin
            xs = 6'($urandom_range(0, 63));
            hb[2] = hb[1]; hb[1] = hb[0]; hb[0] = xs;
            hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = int'($signed(xs));
            expY = c2[0]*hist[0] + c2[1]*hist[1] + c2[2]*hist[2];
            @(negedge clk);
            bus2.in_valid = 1'b1;
            bus2.x_in     = xs;
            cyc = 0;
            while (!bus2.in_ready && cyc < 50) begin
                @(negedge clk);
                cyc++;
            end
            if (!bus2.in_ready) begin
                checkOutput("gen_accept", 0, 1);
                bus2.in_valid = 1'b0;
                break;
            end
            @(posedge clk);
            #1;
            bus2.in_valid = 1'b0;
            lutErr = 0;
            for (int s = 0; s < 6; s++) begin
                expL = 0;
                for (int k = 0; k < 3; k++) begin
                    if (hb[k][5-s]) expL += c2[k];
                end
                if (int'(bus2.lut) != expL) lutErr++;
                @(posedge clk);
                #1;
            end
            checkOutput($sformatf("gen%0d_lut_errors", i), lutErr, 0);
            checkOutput($sformatf("gen%0d_out_valid", i), int'(bus2.out_valid), 1);
            checkOutput($sformatf("gen%0d_y", i), int'(bus2.y), expY);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
